fht_1d_x8_stream: RTL and testbench

Streaming, parametrised successor of the 8-point 1D Fast Hartley Transform (decimation in frequency). It accepts signed samples of configurable width through a valid/ready handshake and buffers frames in ping-pong banks. It computes the transform in a stallable 3-stage pipeline and emits h0..h7 in natural order through a valid/ready output with a frame-last marker. It sits between the row/column sample source and the transpose memory of the 2D FHT, and sustains 1 sample/cycle with no inter-frame gaps.

---
 rtl/fht_1d_x8_stream.sv | 237 +++++++++++++++++++++++
 tb/tb_fht_1d_x8_stream.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fht_1d_x8_stream.sv
// Streaming 8-point 1D Fast Hartley Transform (decimation in frequency).
// Ping-pong input banks feed a stallable 3-stage pipeline. The last stage
// writes straight into one of two output banks, and a serializer emits
// h0..h7 in natural order.
// Optional build macro: FHT_ROUND_EN selects round-half-up multiplier
// products. When the macro is undefined, the products are floored.
module fht_1d_x8_stream #(
  parameter int DW = 8,
  parameter int CW = 14
) (
  input  logic                 sclk,
  input  logic                 rst,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic signed [DW-1:0] x_data,
  output logic                 h_valid,
  input  logic                 h_ready,
  output logic signed [DW+2:0] h_data,
  output logic                 h_last,
  output logic                 busy
);

  localparam int SW = DW + 1;       // stage-1 width
  localparam int TW = DW + 2;       // stage-2 width
  localparam int HW = DW + 3;       // result width
  localparam int PW = DW + CW + 3;  // multiplier product width

  // round(sqrt(2) * 2^cw), computed bit by bit as an integer square root
  function automatic longint sqrt2_const(input int cw);
    longint n;
    longint r;
    longint t;
    n = 64'sd2 << (2 * cw);
    r = 64'sd0;
    for (int b = 31; b >= 0; b--) begin
      t = r | (64'sd1 << b);
      r = ((t * t) <= n) ? t : r;
    end
    r = ((n - r * r) > r) ? (r + 64'sd1) : r;
    return r;
  endfunction

  localparam int K = int'(sqrt2_const(CW));
  localparam logic signed [PW-1:0] K_P = PW'(K);
`ifdef FHT_ROUND_EN
  localparam logic signed [PW-1:0] R_P = PW'(64'sd1 <<< (CW - 1));
`else
  localparam logic signed [PW-1:0] R_P = {PW{1'b0}};
`endif

  // input collector state
  logic signed [DW-1:0] ibank [2][8];
  logic [2:0]           wr_cnt_r;
  logic                 wr_bank_r;
  logic                 ld_bank_r;
  logic [1:0]           ibank_full_r;

  // pipeline state
  logic                 s1_valid_r;
  logic signed [SW-1:0] s1_s_r [4];
  logic signed [SW-1:0] s1_d_r [4];
  logic                 s2_valid_r;
  logic signed [TW-1:0] s2_ap_r, s2_am_r, s2_bp_r, s2_bm_r;
  logic signed [TW-1:0] s2_cp_r, s2_cm_r, s2_m1_r, s2_m3_r;

  // output bank state
  logic signed [HW-1:0] obank [2][8];
  logic [1:0]           ob_full_r;
  logic                 ob_wr_r;
  logic                 ob_rd_r;
  logic [2:0]           rd_idx_r;

  // combinational helpers
  logic                 x_fire;
  logic                 stall;
  logic                 launch;
  logic                 ob_write;
  logic                 h_fire;
  logic signed [SW-1:0] s1_sum [4];
  logic signed [SW-1:0] s1_dif [4];
  logic signed [PW-1:0] prod1, prod3;
  logic signed [HW-1:0] h3 [8];

  // A write bank that is still waiting for launch blocks the input.
  assign x_ready  = !rst && !ibank_full_r[wr_bank_r];
  assign x_fire   = x_valid && x_ready;
  // The output bank doubles as the stage-3 register, so a full target bank
  // freezes the whole pipeline.
  assign stall    = s2_valid_r && ob_full_r[ob_wr_r];
  assign launch   = ibank_full_r[ld_bank_r] && !stall;
  assign ob_write = s2_valid_r && !stall;
  assign h_valid  = ob_full_r[ob_rd_r];
  assign h_last   = h_valid && (rd_idx_r == 3'd7);
  assign h_fire   = h_valid && h_ready;
  assign busy     = (wr_cnt_r != 3'd0) || (ibank_full_r != 2'b00) || s1_valid_r
                    || s2_valid_r || (ob_full_r != 2'b00);

  // Present the current output sample. Drive zero while idle, because
  // bank contents are never reset.
  always_comb begin
    h_data = {HW{1'b0}};
    if (h_valid) begin
      h_data = obank[ob_rd_r][rd_idx_r];
    end else begin
      h_data = {HW{1'b0}};
    end
  end

  // Input collector: write counter, bank toggling, full flags and launch order.
  always_ff @(posedge sclk) begin
    if (rst) begin
      wr_cnt_r     <= 3'd0;
      wr_bank_r    <= 1'b0;
      ld_bank_r    <= 1'b0;
      ibank_full_r <= 2'b00;
    end else begin
      if (x_fire) begin
        wr_cnt_r <= wr_cnt_r + 3'd1;
        if (wr_cnt_r == 3'd7) begin
          ibank_full_r[wr_bank_r] <= 1'b1;
          wr_bank_r               <= ~wr_bank_r;
        end
      end
      // The launched bank is always the other bank, because a full write
      // bank holds x_ready low.
      if (launch) begin
        ibank_full_r[ld_bank_r] <= 1'b0;
        ld_bank_r               <= ~ld_bank_r;
      end
    end
  end

  // Input bank storage (not reset).
  always_ff @(posedge sclk) begin
    if (x_fire) begin
      ibank[wr_bank_r][wr_cnt_r] <= x_data;
    end
  end

  // Stage-1 butterflies on the bank being launched.
  always_comb begin
    s1_sum[0] = SW'(ibank[ld_bank_r][0]) + SW'(ibank[ld_bank_r][4]);
    s1_sum[1] = SW'(ibank[ld_bank_r][1]) + SW'(ibank[ld_bank_r][5]);
    s1_sum[2] = SW'(ibank[ld_bank_r][2]) + SW'(ibank[ld_bank_r][6]);
    s1_sum[3] = SW'(ibank[ld_bank_r][3]) + SW'(ibank[ld_bank_r][7]);
    s1_dif[0] = SW'(ibank[ld_bank_r][0]) - SW'(ibank[ld_bank_r][4]);
    s1_dif[1] = SW'(ibank[ld_bank_r][1]) - SW'(ibank[ld_bank_r][5]);
    s1_dif[2] = SW'(ibank[ld_bank_r][2]) - SW'(ibank[ld_bank_r][6]);
    s1_dif[3] = SW'(ibank[ld_bank_r][3]) - SW'(ibank[ld_bank_r][7]);
  end

  // sqrt(2) scaling of d1 and d3, including the optional rounding offset.
  always_comb begin
    prod1 = PW'(s1_d_r[1]) * K_P + R_P;
    prod3 = PW'(s1_d_r[3]) * K_P + R_P;
  end

  // Stage-3 combine, written into the free output bank.
  always_comb begin
    h3[0] = HW'(s2_ap_r) + HW'(s2_bp_r);
    h3[4] = HW'(s2_ap_r) - HW'(s2_bp_r);
    h3[2] = HW'(s2_am_r) + HW'(s2_bm_r);
    h3[6] = HW'(s2_am_r) - HW'(s2_bm_r);
    h3[1] = HW'(s2_cp_r) + HW'(s2_m1_r);
    h3[5] = HW'(s2_cp_r) - HW'(s2_m1_r);
    h3[3] = HW'(s2_cm_r) + HW'(s2_m3_r);
    h3[7] = HW'(s2_cm_r) - HW'(s2_m3_r);
  end

  // Pipeline occupancy. Every stage holds while stalled.
  always_ff @(posedge sclk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else if (!stall) begin
      s1_valid_r <= launch;
      s2_valid_r <= s1_valid_r;
    end
  end

  // Pipeline data registers (not reset, qualified by the valids).
  always_ff @(posedge sclk) begin
    if (!stall) begin
      if (launch) begin
        s1_s_r <= s1_sum;
        s1_d_r <= s1_dif;
      end
      if (s1_valid_r) begin
        s2_ap_r <= TW'(s1_s_r[0]) + TW'(s1_s_r[2]);
        s2_am_r <= TW'(s1_s_r[0]) - TW'(s1_s_r[2]);
        s2_bp_r <= TW'(s1_s_r[1]) + TW'(s1_s_r[3]);
        s2_bm_r <= TW'(s1_s_r[1]) - TW'(s1_s_r[3]);
        s2_cp_r <= TW'(s1_d_r[0]) + TW'(s1_d_r[2]);
        s2_cm_r <= TW'(s1_d_r[0]) - TW'(s1_d_r[2]);
        s2_m1_r <= TW'(prod1 >>> CW);
        s2_m3_r <= TW'(prod3 >>> CW);
      end
    end
  end

  // Output bank bookkeeping: in-order fill, in-order drain, free on h7.
  always_ff @(posedge sclk) begin
    if (rst) begin
      ob_full_r <= 2'b00;
      ob_wr_r   <= 1'b0;
      ob_rd_r   <= 1'b0;
      rd_idx_r  <= 3'd0;
    end else begin
      if (ob_write) begin
        ob_full_r[ob_wr_r] <= 1'b1;
        ob_wr_r            <= ~ob_wr_r;
      end
      if (h_fire) begin
        rd_idx_r <= rd_idx_r + 3'd1;
        if (rd_idx_r == 3'd7) begin
          ob_full_r[ob_rd_r] <= 1'b0;
          ob_rd_r            <= ~ob_rd_r;
        end
      end
    end
  end

  // Output bank storage (not reset).
  always_ff @(posedge sclk) begin
    if (ob_write) begin
      obank[ob_wr_r][0] <= h3[0];
      obank[ob_wr_r][1] <= h3[1];
      obank[ob_wr_r][2] <= h3[2];
      obank[ob_wr_r][3] <= h3[3];
      obank[ob_wr_r][4] <= h3[4];
      obank[ob_wr_r][5] <= h3[5];
      obank[ob_wr_r][6] <= h3[6];
      obank[ob_wr_r][7] <= h3[7];
    end
  end

endmodule

// File: tb/tb_fht_1d_x8_stream.sv
// Scoreboard bench for fht_1d_x8_stream (DW=8, CW=14).
module tb_fht_1d_x8_stream;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic               rst;
  logic               x_valid;
  logic               x_ready;
  logic signed [7:0]  x_data;
  logic               h_valid;
  logic               h_ready;
  logic signed [10:0] h_data;
  logic               h_last;
  logic               busy;

  fht_1d_x8_stream #(.DW(8), .CW(14)) dut (
    .sclk(sclk), .rst(rst),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
    .h_valid(h_valid), .h_ready(h_ready), .h_data(h_data), .h_last(h_last),
    .busy(busy)
  );

  typedef struct {
    logic signed [10:0] v;
    logic               last;
    int                 idx;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int h0_cyc = -1;
  bit mon_en = 1'b0;
  bit stream_mode = 1'b0;
  int stream_pops = 0;
  int stream_gaps = 0;
  int last_pop = 0;
  bit hold_pend = 1'b0;
  int hold_val = 0;

`ifdef FHT_ROUND_EN
  localparam int RND = 8192;
`else
  localparam int RND = 0;
`endif

  always @(posedge sclk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // floor((d*K + R) / 2^14) with K = 23170
  function automatic int mul_k(input int d);
    int num;
    int q;
    num = d * 23170 + RND;
    q = num / 16384;
    if (num < 0 && q * 16384 != num) q = q - 1;
    return q;
  endfunction

  task automatic push_list(input int e[8]);
    exp_t t;
    for (int i = 0; i < 8; i++) begin
      t.v = 11'(e[i]);
      t.last = (i == 7);
      t.idx = i;
      sb.push_back(t);
    end
  endtask

  task automatic push_model(input logic [63:0] f);
    int x[8];
    int s[4];
    int d[4];
    int e[8];
    int a0, a1, b0, b1, c0, c1, m1, m3;
    for (int n = 0; n < 8; n++) x[n] = int'($signed(f[8*n +: 8]));
    for (int n = 0; n < 4; n++) begin
      s[n] = x[n] + x[n+4];
      d[n] = x[n] - x[n+4];
    end
    a0 = s[0] + s[2]; a1 = s[0] - s[2];
    b0 = s[1] + s[3]; b1 = s[1] - s[3];
    c0 = d[0] + d[2]; c1 = d[0] - d[2];
    m1 = mul_k(d[1]); m3 = mul_k(d[3]);
    e = '{a0 + b0, c0 + m1, a1 + b1, c1 + m3, a0 - b0, c0 - m1, a1 - b1, c1 - m3};
    push_list(e);
  endtask

  // Drive one sample; returns the cycle it was accepted and the cycles waited.
  task automatic put(input logic [7:0] v, output int acc, output int waited);
    bit ok;
    ok = 1'b0;
    waited = 0;
    acc = -1;
    x_valid = 1'b1;
    x_data = v;
    while (!ok && waited < 200) begin
      @(negedge sclk);
      ok = x_ready;
      if (ok) acc = cyc;
      else waited++;
      @(posedge sclk);
      #1;
    end
    if (!ok) begin
      checks++;
      $display("FAIL put_timeout: x_ready stayed 0 for %0d cycles, required 1", waited);
    end
  endtask

  task automatic send_frame(input logic [63:0] f, output int x0c, output int stalls);
    int a;
    int w;
    stalls = 0;
    x0c = -1;
    for (int n = 0; n < 8; n++) begin
      put(f[8*n +: 8], a, w);
      stalls += w;
      if (n == 0) x0c = a;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge sclk);
      n++;
    end
    #1;
    chk(name, sb.size(), 0);
  endtask

  // Monitor: pops the scoreboard on each output handshake and checks that
  // a held output stays unchanged.
  always @(negedge sclk) begin
    exp_t e;
    if (mon_en) begin
      if (hold_pend) chk("h_hold_stable", int'({h_valid, h_last, h_data}), hold_val);
      hold_pend = h_valid && !h_ready;
      hold_val = int'({h_valid, h_last, h_data});
      if (h_valid && h_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL h_unexpected: got h_data %0d with empty scoreboard, required no output", h_data);
        end else begin
          e = sb.pop_front();
          chk($sformatf("h_data[%0d]", e.idx), int'(h_data), int'(e.v));
          chk($sformatf("h_last[%0d]", e.idx), int'(h_last), int'(e.last));
          if (e.idx == 0) h0_cyc = cyc;
          if (stream_mode) begin
            if (stream_pops > 0 && cyc != last_pop + 1) stream_gaps++;
            last_pop = cyc;
            stream_pops++;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int e[8];
    int x0c;
    int st;
    int tot;
    int a;
    int w;
    int hi;
    logic [63:0] f;

    rst = 1'b1; x_valid = 1'b0; x_data = 8'sd0; h_ready = 1'b1;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    chk("rst_x_ready", int'(x_ready), 0);
    chk("rst_h_valid", int'(h_valid), 0);
    chk("rst_h_data", int'(h_data), 0);
    chk("rst_h_last", int'(h_last), 0);
    chk("rst_busy", int'(busy), 0);
    @(posedge sclk); #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge sclk);
    chk("x_ready_after_rst", int'(x_ready), 1);
    @(posedge sclk); #1;

    // impulse x0 = 100
    e = '{100, 100, 100, 100, 100, 100, 100, 100};
    push_list(e);
    send_frame(64'h0000_0000_0000_0064, x0c, st);
    x_valid = 1'b0;
    drain("drain_impulse");
    chk("latency_h0", h0_cyc - x0c, 11);

    // x1 = -100, then all -128, back to back
`ifdef FHT_ROUND_EN
    e = '{-100, -141, -100, 0, 100, 141, 100, 0};
`else
    e = '{-100, -142, -100, 0, 100, 142, 100, 0};
`endif
    push_list(e);
    send_frame(64'h0000_0000_0000_9C00, x0c, st);
    e = '{-1024, 0, 0, 0, 0, 0, 0, 0};
    push_list(e);
    send_frame(64'h8080_8080_8080_8080, x0c, st);
    x_valid = 1'b0;
    drain("drain_directed");

    // 16 back-to-back random frames at full rate
    stream_mode = 1'b1;
    tot = 0;
    for (int k = 0; k < 16; k++) begin
      f = {$urandom, $urandom};
      push_model(f);
      send_frame(f, x0c, st);
      tot += st;
    end
    x_valid = 1'b0;
    drain("drain_stream");
    stream_mode = 1'b0;
    chk("stream_x_ready_stalls", tot, 0);
    chk("stream_h_gaps", stream_gaps, 0);
    chk("stream_pops", stream_pops, 128);

    // downstream blocked: five frames fit, then x_ready drops
    h_ready = 1'b0;
    tot = 0;
    for (int k = 0; k < 5; k++) begin
      f = {$urandom, $urandom};
      push_model(f);
      send_frame(f, x0c, st);
      tot += st;
    end
    x_valid = 1'b0;
    chk("hold_5_frames_no_stall", tot, 0);
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge sclk);
      if (x_ready) hi++;
    end
    chk("hold_x_ready_low", hi, 0);
    chk("hold_busy", int'(busy), 1);
    @(posedge sclk); #1;
    for (int k = 0; k < 600 && sb.size() != 0; k++) begin
      h_ready = 1'($urandom_range(0, 1));
      @(posedge sclk); #1;
    end
    h_ready = 1'b1;
    drain("drain_hold");

    // reset after x3 of a frame, with the previous frame still draining
    f = {$urandom, $urandom};
    push_model(f);
    send_frame(f, x0c, st);
    for (int n = 0; n < 4; n++) put(8'(n + 5), a, w);
    rst = 1'b1;
    x_valid = 1'b0;
    @(posedge sclk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge sclk);
    chk("mid_rst_x_ready", int'(x_ready), 1);
    chk("mid_rst_h_valid", int'(h_valid), 0);
    chk("mid_rst_h_data", int'(h_data), 0);
    chk("mid_rst_h_last", int'(h_last), 0);
    chk("mid_rst_busy", int'(busy), 0);
    @(posedge sclk); #1;
    e = '{-1024, 0, 0, 0, 0, 0, 0, 0};
    push_list(e);
    send_frame(64'h8080_8080_8080_8080, x0c, st);
    x_valid = 1'b0;
    drain("drain_after_rst");
    chk("latency_after_rst", h0_cyc - x0c, 11);

    repeat (20) @(posedge sclk);
    #1;
    chk("final_idle_busy", int'(busy), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
